// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller slice.
//   CTRL_ST_WIDTH  : width of the controller state encoding (2 bits)
//   ctrl_state_e   : CTRL_ST_RUN    - no pause outstanding
//                    CTRL_ST_PAUSED - one or more stages hold a pending pause
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int CTRL_ST_WIDTH = 2;

   typedef enum logic [CTRL_ST_WIDTH-1:0] {
      CTRL_ST_RUN    = 2'd0,
      CTRL_ST_PAUSED = 2'd1
   } ctrl_state_e;

endpackage

// File: rtl/pause_wdt.sv
// ---------------------------------------------------------------------------
// pause_wdt
// Pause watchdog: a saturating cycle counter plus a sticky error flag.
// Only built when PIPE_CTRL_WATCHDOG_EN is defined.
// Ports:
//   clk   in  clock
//   rst   in  asynchronous, active-low reset
//   clr   in  zero the counter (held while the controller is running)
//   inc   in  count one paused cycle
//   fire  out the current paused cycle is the last one allowed
//   err   out sticky; the watchdog has fired since reset
// ---------------------------------------------------------------------------
module pause_wdt #(
   parameter int PAUSE_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic fire,
   output logic err
);

   localparam int CNT_W = $clog2(PAUSE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(PAUSE_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PAUSE_MAX);

   logic [CNT_W-1:0] cnt;

   // The counter reads k during the (k+1)-th paused cycle, so the fire
   // cycle is the PAUSE_MAX-th paused cycle.
   assign fire = inc & (cnt == CNT_FIRE);

   // Paused-cycle counter; it saturates rather than wrapping so a stray
   // extra increment can never re-arm an early fire.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_SAT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Sticky error: once set it is only cleared by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err <= 1'b0;
      end else if (fire) begin
         err <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Parametrised pipeline hazard controller. Arbitrates per-stage pause,
// unpause and redirect (flush) requests into per-stage stall / flush /
// bubble controls. Stage 0 is fetch; higher indices are older stages.
// Configuration macro: PIPE_CTRL_WATCHDOG_EN
//   defined   -> pause watchdog (pause_wdt) bounds every pause
//   undefined -> no watchdog, timeout_err tied low, pauses are unbounded
// Ports:
//   clk          in   clock
//   rst          in   asynchronous, active-low reset
//   pause_req    in   [STAGES] stage s holds itself and all younger stages
//   unpause      in   [STAGES] stage s's multi-cycle condition resolved
//   flush_req    in   [STAGES] stage s redirects; younger stages are killed
//   stall        out  [STAGES] stage k holds its register
//   flush        out  [STAGES] stage k loads NOP next edge (wrong path)
//   bubble       out  [STAGES] stage k loads NOP because its feeder stalls
//   busy         out  controller is in the PAUSED state
//   timeout_err  out  sticky; the watchdog has fired since reset
// ---------------------------------------------------------------------------
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int STAGES    = 3,
   parameter int PAUSE_MAX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [STAGES-1:0] pause_req,
   input  logic [STAGES-1:0] unpause,
   input  logic [STAGES-1:0] flush_req,
   output logic [STAGES-1:0] stall,
   output logic [STAGES-1:0] flush,
   output logic [STAGES-1:0] bubble,
   output logic              busy,
   output logic              timeout_err
);

   ctrl_state_e       state, state_nxt;
   logic [STAGES-1:0] pend, pend_nxt;
   logic [STAGES-1:0] act;
   logic [STAGES-1:0] stall_raw;
   logic [STAGES-1:0] flush_ok;
   logic              fire;

   assign busy = (state == CTRL_ST_PAUSED);

`ifdef PIPE_CTRL_WATCHDOG_EN
   logic wdt_clr;

   // The counter is held at zero while running, so it starts from zero on
   // the first paused cycle.
   assign wdt_clr = (state == CTRL_ST_RUN);

   pause_wdt #(
      .PAUSE_MAX (PAUSE_MAX)
   ) u_pause_wdt (
      .clk  (clk),
      .rst  (rst),
      .clr  (wdt_clr),
      .inc  (busy),
      .fire (fire),
      .err  (timeout_err)
   );
`else
   logic unused_pause_max;

   assign unused_pause_max = ^PAUSE_MAX;
   assign fire             = 1'b0;
   assign timeout_err      = 1'b0;
`endif

   // Hazard arbitration. An unpause beats a same-cycle pause request, and
   // the oldest active pauser sets the stall depth (it stalls itself and
   // everything younger). A flush from stage s kills every stage below the
   // highest unstalled redirecting stage; "some valid flusher sits above k"
   // is exactly "k < f", so no explicit priority encoder is needed. The same
   // kill mask clears the pending pauses of the killed instructions.
   always_comb begin
      act       = (pend | pause_req) & ~unpause;
      stall_raw = '0;
      flush_ok  = '0;
      flush     = '0;
      stall     = '0;
      bubble    = '0;
      pend_nxt  = '0;
      state_nxt = CTRL_ST_RUN;

      stall_raw[STAGES-1] = act[STAGES-1];
      for (int k = STAGES - 2; k >= 0; k--) begin
         stall_raw[k] = act[k] | stall_raw[k+1];
      end

      flush_ok = flush_req & ~stall_raw;
      for (int k = STAGES - 2; k >= 0; k--) begin
         flush[k] = flush_ok[k+1] | flush[k+1];
      end

      stall = stall_raw & ~flush;

      for (int k = 1; k < STAGES; k++) begin
         bubble[k] = stall[k-1] & ~stall[k] & ~flush[k];
      end

      pend_nxt = act & ~flush;
      if (fire) begin
         pend_nxt = '0;
      end

      if (pend_nxt != '0) begin
         state_nxt = CTRL_ST_PAUSED;
      end
   end

   // State and pending-pause registers; reset aborts any pause at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= CTRL_ST_RUN;
         pend  <= '0;
      end else begin
         state <= state_nxt;
         pend  <= pend_nxt;
      end
   end

endmodule
